// File: rtl/uart_rx_fifo.sv
// Captures one RX byte per DV assertion into a FWFT FIFO (1-cycle write-to-read) and acks it with CLR_DV.
// Pushes into a full FIFO without a pop are dropped; UART_RX_FIFO_OVR_EN adds a sticky OVR flag with CLR_OVR.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DV,
  input  logic [DATA_W-1:0]     RX_DATA,
  output logic                  CLR_DV,
  output logic [DATA_W-1:0]     DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic [DEPTH_LOG2:0]   LEVEL
`ifdef UART_RX_FIFO_OVR_EN
  ,
  output logic                  OVR,
  input  logic                  CLR_OVR
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    ARMED = 1'b0,
    ACK   = 1'b1
  } cap_state_t;

  cap_state_t              state_q;
  logic                    clr_dv_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q;
  logic [DEPTH_LOG2-1:0]   rptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic [DEPTH_LOG2:0]     level_d;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    wr_en;

  // CLR_DV follows the state register so the ack is glitch-free toward the controller.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ARMED;
      clr_dv_q <= 1'b0;
    end else begin
      case (state_q)
        ARMED: if (DV) begin
          state_q  <= ACK;
          clr_dv_q <= 1'b1;
        end
        ACK: if (!DV) begin
          state_q  <= ARMED;
          clr_dv_q <= 1'b0;
        end
      endcase
    end
  end

  assign push  = (state_q == ARMED) && DV;
  assign full  = (level_q == FULL_LVL);
  assign pop   = DOUT_READY && (level_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wptr_q] <= RX_DATA;
  end

`ifdef UART_RX_FIFO_OVR_EN
  logic ovr_q;
  logic drop;

  assign drop = push && full && !pop;

  // A new drop wins over a coincident clear.
  always_ff @(posedge CLK) begin
    if (RST)          ovr_q <= 1'b0;
    else if (drop)    ovr_q <= 1'b1;
    else if (CLR_OVR) ovr_q <= 1'b0;
  end

  assign OVR = ovr_q;
`endif

  assign CLR_DV     = clr_dv_q;
  assign DOUT       = mem_q[rptr_q];
  assign DOUT_VALID = (level_q != '0);
  assign LEVEL      = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DV;
  logic [7:0] RX_DATA;
  logic       CLR_DV;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY;
  logic [4:0] LEVEL;
  logic       CLR_OVR;
`ifdef UART_RX_FIFO_OVR_EN
  logic       OVR;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: stored bytes, last DV seen at an edge, expected ack and overrun.
  byte unsigned q[$];
  bit prev_dv;
  bit exp_clr;
  bit exp_ovr;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DV         (DV),
    .RX_DATA    (RX_DATA),
    .CLR_DV     (CLR_DV),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .LEVEL      (LEVEL)
`ifdef UART_RX_FIFO_OVR_EN
    ,
    .OVR        (OVR),
    .CLR_OVR    (CLR_OVR)
`endif
  );

  always #5 CLK = ~CLK;

  // One clock edge: update the model from the inputs seen at the edge, then settle.
  task automatic step();
    bit full_now;
    bit pop_now;
    bit push_now;
    @(posedge CLK);
    if (RST) begin
      q.delete();
      prev_dv = 1'b0;
      exp_clr = 1'b0;
      exp_ovr = 1'b0;
    end else begin
      full_now = (q.size() == 16);
      pop_now  = DOUT_READY && (q.size() > 0);
      push_now = DV && !prev_dv;
      if (pop_now) void'(q.pop_front());
      if (push_now && (!full_now || pop_now)) q.push_back(RX_DATA);
      if (push_now && full_now && !pop_now) exp_ovr = 1'b1;
      else if (CLR_OVR) exp_ovr = 1'b0;
      exp_clr = DV;
      prev_dv = DV;
    end
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    RX_DATA = b;
    DV = 1'b1;
    step();
    DV = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1; DV = 1'b0; RX_DATA = 8'h00; DOUT_READY = 1'b0; CLR_OVR = 1'b0;
    step();
    step();
    RST = 1'b0;
    n_cmp++; if (LEVEL !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
    n_cmp++; if (DOUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", DOUT_VALID); end
    n_cmp++; if (CLR_DV !== 1'b0) begin n_fail++; $display("FAIL reset_clr_dv: got %b want 0", CLR_DV); end
`ifdef UART_RX_FIFO_OVR_EN
    n_cmp++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", OVR); end
`endif
  endtask

  task automatic test_single_byte();
    RX_DATA = 8'hA5;
    DV = 1'b1;
    step();
    n_cmp++; if (CLR_DV !== 1'b1) begin n_fail++; $display("FAIL single_clr_dv1: got %b want 1", CLR_DV); end
    n_cmp++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'hA5) begin n_fail++; $display("FAIL single_dout: got v=%b %h want v=1 a5", DOUT_VALID, DOUT); end
    n_cmp++; if (LEVEL !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", LEVEL); end
    step();
    n_cmp++; if (CLR_DV !== 1'b1) begin n_fail++; $display("FAIL single_clr_dv2: got %b want 1", CLR_DV); end
    DV = 1'b0;
    step();
    n_cmp++; if (CLR_DV !== 1'b0) begin n_fail++; $display("FAIL single_clr_dv3: got %b want 0", CLR_DV); end
    n_cmp++; if (LEVEL !== 5'd1) begin n_fail++; $display("FAIL single_one_push: got %0d want 1", LEVEL); end
    DOUT_READY = 1'b1;
    step();
    DOUT_READY = 1'b0;
    n_cmp++; if (LEVEL !== 5'd0 || DOUT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_pop: got lvl=%0d v=%b want 0 0", LEVEL, DOUT_VALID); end
  endtask

  task automatic test_long_dv();
    RX_DATA = 8'h3C;
    DV = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (CLR_DV !== 1'b1 || LEVEL !== 5'd1) begin n_fail++; $display("FAIL long_dv_cycle%0d: got clr=%b lvl=%0d want 1 1", i, CLR_DV, LEVEL); end
    end
    DV = 1'b0;
    step();
    n_cmp++; if (CLR_DV !== 1'b0 || DOUT !== 8'h3C) begin n_fail++; $display("FAIL long_dv_end: got clr=%b dout=%h want 0 3c", CLR_DV, DOUT); end
    DOUT_READY = 1'b1;
    step();
    DOUT_READY = 1'b0;
    n_cmp++; if (LEVEL !== 5'd0) begin n_fail++; $display("FAIL long_dv_drain: got %0d want 0", LEVEL); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    n_cmp++; if (LEVEL !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d want 16", LEVEL); end
    DOUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'(i)) begin n_fail++; $display("FAIL fill_pop%0d: got %h want %h", i, DOUT, 8'(i)); end
      step();
    end
    DOUT_READY = 1'b0;
    for (int i = 16; i < 24; i++) push_byte(8'(i));
    n_cmp++; if (LEVEL !== 5'd16) begin n_fail++; $display("FAIL wrap_level: got %0d want 16", LEVEL); end
    DOUT_READY = 1'b1;
    for (int i = 8; i < 24; i++) begin
      n_cmp++; if (DOUT_VALID !== 1'b1 || DOUT !== 8'(i)) begin n_fail++; $display("FAIL wrap_pop%0d: got %h want %h", i, DOUT, 8'(i)); end
      step();
    end
    DOUT_READY = 1'b0;
    n_cmp++; if (LEVEL !== 5'd0 || DOUT_VALID !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got lvl=%0d v=%b want 0 0", LEVEL, DOUT_VALID); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    RX_DATA = 8'hFF;
    DV = 1'b1;
    step();
    n_cmp++; if (CLR_DV !== 1'b1 || LEVEL !== 5'd16) begin n_fail++; $display("FAIL ovr_capture: got clr=%b lvl=%0d want 1 16", CLR_DV, LEVEL); end
    DV = 1'b0;
    step();
`ifdef UART_RX_FIFO_OVR_EN
    n_cmp++; if (OVR !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", OVR); end
    CLR_OVR = 1'b1;
    step();
    CLR_OVR = 1'b0;
    n_cmp++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", OVR); end
`endif
    DOUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (DOUT !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL ovr_drain%0d: got %h want %h", i, DOUT, 8'h40 + 8'(i)); end
      step();
    end
    DOUT_READY = 1'b0;
    n_cmp++; if (DOUT_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_lost: got v=%b want 0", DOUT_VALID); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_b;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    RX_DATA = 8'h77;
    DV = 1'b1;
    DOUT_READY = 1'b1;
    step();
    DOUT_READY = 1'b0;
    DV = 1'b0;
    n_cmp++; if (LEVEL !== 5'd16 || DOUT !== 8'h21) begin n_fail++; $display("FAIL full_pp: got lvl=%0d dout=%h want 16 21", LEVEL, DOUT); end
    step();
`ifdef UART_RX_FIFO_OVR_EN
    n_cmp++; if (OVR !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovr: got %b want 0", OVR); end
`endif
    DOUT_READY = 1'b1;
    for (int i = 1; i < 17; i++) begin
      exp_b = (i == 16) ? 8'h77 : 8'h20 + 8'(i);
      n_cmp++; if (DOUT_VALID !== 1'b1 || DOUT !== exp_b) begin n_fail++; $display("FAIL full_pp_drain%0d: got %h want %h", i, DOUT, exp_b); end
      step();
    end
    DOUT_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
    RX_DATA = 8'h64;
    DV = 1'b1;
    step();
    n_cmp++; if (LEVEL !== 5'd5 || CLR_DV !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got lvl=%0d clr=%b want 5 1", LEVEL, CLR_DV); end
    RST = 1'b1;
    DV = 1'b0;
    step();
    RST = 1'b0;
    n_cmp++; if (LEVEL !== 5'd0 || DOUT_VALID !== 1'b0 || CLR_DV !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got lvl=%0d v=%b clr=%b want 0 0 0", LEVEL, DOUT_VALID, CLR_DV); end
    RX_DATA = 8'h5A;
    DV = 1'b1;
    step();
    n_cmp++; if (LEVEL !== 5'd1 || DOUT !== 8'h5A || CLR_DV !== 1'b1) begin n_fail++; $display("FAIL mid_recapture: got lvl=%0d dout=%h clr=%b want 1 5a 1", LEVEL, DOUT, CLR_DV); end
    DV = 1'b0;
    step();
    DOUT_READY = 1'b1;
    step();
    DOUT_READY = 1'b0;
  endtask

  task automatic test_random();
    int rdy_pct;
    int pcts [4] = '{5, 60, 95, 30};
    for (int c = 0; c < 2000; c++) begin
      rdy_pct = pcts[(c / 250) % 4];
      if (!DV) begin
        if ($urandom_range(2) == 0) begin
          DV = 1'b1;
          RX_DATA = 8'($urandom);
        end
      end else if ($urandom_range(1) == 0) begin
        DV = 1'b0;
      end
      DOUT_READY = ($urandom_range(99) < rdy_pct);
      CLR_OVR = ($urandom_range(31) == 0);
      RST = ($urandom_range(599) == 0);
      step();
      n_cmp++; if (LEVEL !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, LEVEL, q.size()); end
      n_cmp++; if (DOUT_VALID !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, DOUT_VALID, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (DOUT !== q[0]) begin n_fail++; $display("FAIL rnd_dout c%0d: got %h want %h", c, DOUT, q[0]); end
      end
      n_cmp++; if (CLR_DV !== exp_clr) begin n_fail++; $display("FAIL rnd_clr_dv c%0d: got %b want %b", c, CLR_DV, exp_clr); end
`ifdef UART_RX_FIFO_OVR_EN
      n_cmp++; if (OVR !== exp_ovr) begin n_fail++; $display("FAIL rnd_ovr c%0d: got %b want %b", c, OVR, exp_ovr); end
`endif
    end
    RST = 1'b0;
    CLR_OVR = 1'b0;
    DOUT_READY = 1'b0;
    DV = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_long_dv();
    test_fill_wrap();
    test_overrun();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
